// File: rtl/sram_req_ctrl_if.sv
// Request/response stream and SRAM macro bus for sram_req_ctrl.
// The slave modport is the controller's view; master is the environment
// (client plus SRAM wrapper).
interface sram_req_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = 10,
    parameter int BE_W       = (DATA_WIDTH + 7) / 8
);
    // client request stream
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_W-1:0]       req_be;
    // client read-response stream
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    // SRAM macro bus
    logic                  sram_req;
    logic                  sram_we;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [BE_W-1:0]       sram_be;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM initiator: turns a valid/ready request stream into SRAM
// accesses, buffers read data in a small FIFO so the consumer may stall, and
// optionally zero-fills the whole array after reset.
module sram_req_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_WORDS     = 1024,
    parameter int INIT_ON_RESET = 1,
    parameter int RSP_DEPTH     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            init_busy_o,
    sram_req_ctrl_if.slave  bus
);
    localparam int BE_W   = (DATA_WIDTH + 7) / 8;
    localparam int ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = $clog2(RSP_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     init_cnt_q, init_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic           push, pop, accept, can_read;
    logic [CNT_W:0] credit;

    // A read occupies a FIFO slot from accept onward (in flight, then
    // buffered), so credit bounds the FIFO without any overflow check.
    assign push     = inflight_q;
    assign pop      = (count_q != '0) && bus.rsp_ready;
    assign credit   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign can_read = (credit < DEPTH_C) || ((credit == DEPTH_C) && pop);

    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_rdata = mem_q[rd_ptr_q];

    // FSM next state, request acceptance and SRAM bus drive
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        init_busy_o    = 1'b0;
        bus.req_ready  = 1'b0;
        bus.sram_req   = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        bus.sram_be    = '0;
        accept         = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy_o   = 1'b1;
                bus.sram_req  = 1'b1;
                bus.sram_we   = 1'b1;
                bus.sram_addr = init_cnt_q;
                bus.sram_be   = '1;
                init_cnt_d    = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            default: begin
                bus.req_ready = bus.req_we | can_read;
                accept        = bus.req_valid & bus.req_ready;
                if (accept) begin
                    bus.sram_req   = 1'b1;
                    bus.sram_we    = bus.req_we;
                    bus.sram_addr  = bus.req_addr;
                    bus.sram_wdata = bus.req_wdata;
                    bus.sram_be    = bus.req_be;
                end
            end
        endcase
        // nothing reaches the macro or the client while reset is held
        if (rst_i) begin
            bus.req_ready = 1'b0;
            bus.sram_req  = 1'b0;
            accept        = 1'b0;
        end
    end

    // response FIFO pointer/count next state
    always_comb begin
        inflight_d = accept & ~bus.req_we;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // SRAM read data lands in the FIFO the cycle after the read was issued
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_ptr_q] <= bus.sram_rdata;
    end

    a_fifo_bound: assert property (@(posedge clk_i) {1'b0, count_q} <= DEPTH_C);
    a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
                                   (bus.rsp_valid && !bus.rsp_ready) |=> $stable(bus.rsp_rdata));
    a_no_req_rst: assert property (@(posedge clk_i) rst_i |-> !bus.sram_req);

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl: a behavioural SRAM with 1-cycle read
// latency, a shadow memory and a queue of expected read responses.
module tb_sram_req_ctrl;
    localparam int DW = 16;
    localparam int NW = 12;
    localparam int AW = 4;
    localparam int BW = 2;

    logic clk;
    logic rst;
    logic init_busy;

    sram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .BE_W(BW)) bus ();

    sram_req_ctrl #(
        .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_ON_RESET(1), .RSP_DEPTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .init_busy_o(init_busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural SRAM macro
    logic [DW-1:0] smem [16];
    logic [DW-1:0] srd;
    assign bus.sram_rdata = srd;
    always @(posedge clk) begin
        if (bus.sram_req) begin
            if (bus.sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (bus.sram_be[b]) smem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
            end else begin
                srd <= smem[bus.sram_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] expq [$];
    logic [DW-1:0] shadow [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, '0, '0, '0);
    endtask

    // one clock: scoreboard at the falling edge, then advance past the rising edge
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (!rst) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_pending", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("rsp_data", 32'(bus.rsp_rdata), 32'(e));
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    for (int b = 0; b < BW; b++)
                        if (bus.req_be[b]) shadow[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                end else begin
                    expq.push_back(shadow[bus.req_addr]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        expq.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
    endtask

    task automatic check_init(input bit req_pending);
        for (int i = 0; i < NW; i++) begin
            #2;
            chk("init_req",   32'(bus.sram_req),   32'd1);
            chk("init_we",    32'(bus.sram_we),    32'd1);
            chk("init_addr",  32'(bus.sram_addr),  32'(i));
            chk("init_wdata", 32'(bus.sram_wdata), 32'd0);
            chk("init_be",    32'(bus.sram_be),    32'h3);
            chk("init_busy",  32'(init_busy),      32'd1);
            chk("init_ready", 32'(bus.req_ready),  32'd0);
            chk("init_rspv",  32'(bus.rsp_valid),  32'd0);
            if (req_pending) chk("init_valid_held", 32'(bus.req_valid), 32'd1);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) smem[i] = 16'hDEAD;
        srd = '0;
        clear_model();

        // reset held: macro idle
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_sram_req", 32'(bus.sram_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: post-reset state and the zero-fill
        #1;
        chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        check_init(1'b0);
        #2;
        chk("run_busy", 32'(init_busy), 32'd0);
        chk("run_ready", 32'(bus.req_ready), 32'd1);
        chk("run_idle_req", 32'(bus.sram_req), 32'd0);

        // 2: back-to-back reads, latency 2
        bus.rsp_ready = 1'b1;
        drv(1'b1, 1'b1, 4'd3, 16'hA5A5, 2'b11); tick();
        drv(1'b1, 1'b1, 4'd4, 16'h5A5A, 2'b11); tick();
        drv(1'b1, 1'b0, 4'd3, '0, '0);
        #2;
        chk("rd_req", 32'(bus.sram_req), 32'd1);
        chk("rd_we", 32'(bus.sram_we), 32'd0);
        chk("rd_addr", 32'(bus.sram_addr), 32'd3);
        tick();
        drv(1'b1, 1'b0, 4'd4, '0, '0);
        #2; chk("lat_n1_rspv", 32'(bus.rsp_valid), 32'd0);
        tick();
        idle();
        #2;
        chk("lat_n2_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("lat_n2_data", 32'(bus.rsp_rdata), 32'hA5A5);
        tick();
        #2;
        chk("lat_n3_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("lat_n3_data", 32'(bus.rsp_rdata), 32'h5A5A);
        tick();
        #2; chk("lat_n4_rspv", 32'(bus.rsp_valid), 32'd0);

        // 3: consumer stall, credit limit, write still accepted
        bus.rsp_ready = 1'b0;
        drv(1'b1, 1'b0, 4'd3, '0, '0); tick();
        drv(1'b1, 1'b0, 4'd4, '0, '0); tick();
        drv(1'b1, 1'b0, 4'd3, '0, '0);
        #2;
        chk("stall_ready", 32'(bus.req_ready), 32'd0);
        chk("stall_sram_req", 32'(bus.sram_req), 32'd0);
        tick();
        #2; chk("stall_ready2", 32'(bus.req_ready), 32'd0);
        drv(1'b1, 1'b1, 4'd7, 16'h1234, 2'b11);
        #1;
        chk("stall_wr_ready", 32'(bus.req_ready), 32'd1);
        chk("stall_wr_req", 32'(bus.sram_req), 32'd1);
        tick();
        drv(1'b1, 1'b0, 4'd3, '0, '0);
        bus.rsp_ready = 1'b1;
        #2;
        chk("drain_ready", 32'(bus.req_ready), 32'd1);
        chk("drain_head", 32'(bus.rsp_rdata), 32'hA5A5);
        tick();
        idle();
        repeat (4) tick();

        // 4: partial byte-enable write over existing data
        drv(1'b1, 1'b1, 4'd7, 16'hFF00, 2'b01); tick();
        drv(1'b1, 1'b0, 4'd7, '0, '0); tick();
        idle(); tick();
        #2;
        chk("be_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("be_data", 32'(bus.rsp_rdata), 32'h1200);
        tick();

        // 5: reset with one response buffered and one read in flight
        bus.rsp_ready = 1'b0;
        drv(1'b1, 1'b0, 4'd3, '0, '0); tick();
        drv(1'b1, 1'b0, 4'd4, '0, '0); tick();
        idle();
        #2; chk("pre_rst_rspv", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        #1; chk("mid_rst_sram_req", 32'(bus.sram_req), 32'd0);
        tick();
        rst = 1'b0;
        clear_model();
        // 6: request held through the refill, stale data must never appear
        bus.rsp_ready = 1'b1;
        drv(1'b1, 1'b1, 4'd9, 16'hBEEF, 2'b11);
        #1;
        chk("post_rst_rspv", 32'(bus.rsp_valid), 32'd0);
        check_init(1'b1);
        #2;
        chk("first_run_ready", 32'(bus.req_ready), 32'd1);
        chk("first_run_req", 32'(bus.sram_req), 32'd1);
        chk("first_run_addr", 32'(bus.sram_addr), 32'd9);
        chk("first_run_wdata", 32'(bus.sram_wdata), 32'hBEEF);
        tick();
        drv(1'b1, 1'b0, 4'd9, '0, '0); tick();
        drv(1'b1, 1'b0, 4'd3, '0, '0); tick();
        idle();
        repeat (4) tick();
        chk("drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
